// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetch stage sitting after the PC register. Issues one single-beat read
//   on the instruction bus per fetchStart, holds the returned word with its
//   PC until decode accepts it. At most one transaction is outstanding.
//   Handles flush of in-flight fetches (draining a bus response that is
//   still owed), misaligned-address faults and a bus-response timeout.
//
// Ports
//   clk, reset          clock (rising edge), async active-low reset
//   fetchStart, nextPC  one-cycle fetch request and its address
//   flush               discard current fetch
//   busAddress, busRead address phase (out); busReady accepts it
//   busDataValid,busData read data phase
//   instruction, instructionPC, instructionValid / instructionAccept
//                       fetched word handshake to decode
//   fetchBusy           state != IDLE
//   fetchFault,faultCode sticky fault: 01 misaligned, 10 timeout
module instruction_fetch #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetchStart,
    input  logic [31:0] nextPC,
    input  logic        flush,
    output logic [31:0] busAddress,
    output logic        busRead,
    input  logic        busReady,
    input  logic        busDataValid,
    input  logic [31:0] busData,
    output logic [31:0] instruction,
    output logic [31:0] instructionPC,
    output logic        instructionValid,
    input  logic        instructionAccept,
    output logic        fetchBusy,
    output logic        fetchFault,
    output logic [1:0]  faultCode
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    localparam logic [1:0] FAULT_NONE      = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN  = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        WAIT_DATA,
        HOLD,
        DRAIN
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [31:0]   addr_nxt, instr_nxt, ipc_nxt;
    logic [1:0]    code_nxt;
    logic          do_start;

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        addr_nxt  = busAddress;
        instr_nxt = instruction;
        ipc_nxt   = instructionPC;
        code_nxt  = faultCode;
        do_start  = 1'b0;

        case (state)
            IDLE: begin
                // flush drops a same-cycle start
                do_start = fetchStart && !flush;
            end
            REQUEST: begin
                if (busReady) begin
                    timer_nxt = '0;
                    // address already accepted: the response must be drained
                    state_nxt = flush ? DRAIN : WAIT_DATA;
                end else if (flush) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_DATA: begin
                if (busDataValid) begin
                    if (flush) begin
                        state_nxt = IDLE;
                    end else begin
                        instr_nxt = busData;
                        ipc_nxt   = busAddress;
                        state_nxt = HOLD;
                    end
                end else if (flush) begin
                    // timer keeps running: the bus still owes this response
                    state_nxt = DRAIN;
                    if (timer != TMAX) timer_nxt = timer + TW'(1);
                end else if (timer == TMAX) begin
                    code_nxt  = FAULT_TIMEOUT;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            DRAIN: begin
                if (busDataValid) begin
                    state_nxt = IDLE;
                end else if (timer == TMAX) begin
                    code_nxt  = FAULT_TIMEOUT;
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            HOLD: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (instructionAccept) begin
                    state_nxt = IDLE;
                    // back-to-back start skips the idle bubble
                    do_start  = fetchStart;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (do_start) begin
            if (nextPC[1:0] != 2'b00) begin
                code_nxt  = FAULT_MISALIGN;
                state_nxt = IDLE;
            end else begin
                code_nxt  = FAULT_NONE;
                addr_nxt  = nextPC;
                state_nxt = REQUEST;
            end
        end
    end

    // Outputs are registered from next-state so they line up with the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            timer            <= '0;
            busAddress       <= '0;
            busRead          <= 1'b0;
            instruction      <= '0;
            instructionPC    <= '0;
            instructionValid <= 1'b0;
            fetchBusy        <= 1'b0;
            fetchFault       <= 1'b0;
            faultCode        <= FAULT_NONE;
        end else begin
            state            <= state_nxt;
            timer            <= timer_nxt;
            busAddress       <= addr_nxt;
            busRead          <= (state_nxt == REQUEST);
            instruction      <= instr_nxt;
            instructionPC    <= ipc_nxt;
            instructionValid <= (state_nxt == HOLD);
            fetchBusy        <= (state_nxt != IDLE);
            fetchFault       <= (code_nxt != FAULT_NONE);
            faultCode        <= code_nxt;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch
//   Directed scenarios followed by randomized traffic, all checked cycle by
//   cycle against a transaction-level model of the fetch unit (address phase
//   pending / response owed / response to be dropped / word held).
module tb_instruction_fetch;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetchStart = 1'b0;
    logic [31:0] nextPC = '0;
    logic        flush = 1'b0;
    logic [31:0] busAddress;
    logic        busRead;
    logic        busReady = 1'b0;
    logic        busDataValid = 1'b0;
    logic [31:0] busData = '0;
    logic [31:0] instruction;
    logic [31:0] instructionPC;
    logic        instructionValid;
    logic        instructionAccept = 1'b0;
    logic        fetchBusy;
    logic        fetchFault;
    logic [1:0]  faultCode;

    instruction_fetch #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .fetchStart(fetchStart), .nextPC(nextPC), .flush(flush),
        .busAddress(busAddress), .busRead(busRead), .busReady(busReady),
        .busDataValid(busDataValid), .busData(busData),
        .instruction(instruction), .instructionPC(instructionPC),
        .instructionValid(instructionValid), .instructionAccept(instructionAccept),
        .fetchBusy(fetchBusy), .fetchFault(fetchFault), .faultCode(faultCode)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference
    bit          m_req, m_out, m_drop, m_hold;
    int          m_wait;
    logic [31:0] m_addr, m_instr, m_pc;
    logic [1:0]  m_code;

    task automatic model_reset();
        m_req = 0; m_out = 0; m_drop = 0; m_hold = 0; m_wait = 0;
        m_addr = '0; m_instr = '0; m_pc = '0; m_code = 2'b00;
    endtask

    task automatic model_step();
        bit go;
        go = 0;
        if (m_req) begin
            if (busReady) begin
                m_out = 1; m_drop = flush; m_wait = 0;
            end
            if (busReady || flush) m_req = 0;
        end else if (m_out) begin
            if (busDataValid) begin
                m_out = 0;
                if (!m_drop && !flush) begin
                    m_hold = 1; m_instr = busData; m_pc = m_addr;
                end
            end else if (m_wait == T && !(flush && !m_drop)) begin
                m_out = 0; m_code = 2'b10;
            end else begin
                if (m_wait < T) m_wait++;
                if (flush) m_drop = 1;
            end
        end else if (m_hold) begin
            if (flush) m_hold = 0;
            else if (instructionAccept) begin
                m_hold = 0; go = fetchStart;
            end
        end else begin
            go = fetchStart && !flush;
        end
        if (go) begin
            if (nextPC[1:0] != 2'b00) m_code = 2'b01;
            else begin
                m_code = 2'b00; m_addr = nextPC; m_req = 1;
            end
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".busRead"}, {31'b0, busRead}, {31'b0, m_req});
        if (m_req) chk({ph, ".busAddress"}, busAddress, m_addr);
        chk({ph, ".valid"}, {31'b0, instructionValid}, {31'b0, m_hold});
        if (m_hold) begin
            chk({ph, ".instruction"}, instruction, m_instr);
            chk({ph, ".instructionPC"}, instructionPC, m_pc);
        end
        chk({ph, ".busy"}, {31'b0, fetchBusy}, {31'b0, (m_req | m_out | m_hold)});
        chk({ph, ".faultCode"}, {30'b0, faultCode}, {30'b0, m_code});
        chk({ph, ".fetchFault"}, {31'b0, fetchFault}, {31'b0, (m_code != 2'b00)});
    endtask

    task automatic check_zero(input string ph);
        chk({ph, ".busRead"}, {31'b0, busRead}, 32'd0);
        chk({ph, ".busAddress"}, busAddress, 32'd0);
        chk({ph, ".instruction"}, instruction, 32'd0);
        chk({ph, ".instructionPC"}, instructionPC, 32'd0);
        chk({ph, ".valid"}, {31'b0, instructionValid}, 32'd0);
        chk({ph, ".busy"}, {31'b0, fetchBusy}, 32'd0);
        chk({ph, ".fetchFault"}, {31'b0, fetchFault}, 32'd0);
        chk({ph, ".faultCode"}, {30'b0, faultCode}, 32'd0);
    endtask

    // Apply one cycle of inputs, advance the model, compare after the edge.
    task automatic cyc(input string ph, input bit st, input logic [31:0] pc,
                       input bit fl, input bit rdy, input bit dv,
                       input logic [31:0] d, input bit acc);
        fetchStart = st; nextPC = pc; flush = fl; busReady = rdy;
        busDataValid = dv; busData = d; instructionAccept = acc;
        model_step();
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    task automatic idle_in();
        fetchStart = 0; flush = 0; busReady = 0; busDataValid = 0; instructionAccept = 0;
    endtask

    initial begin
        model_reset();
        #2;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // basic fetch at 0x100
        cyc("basic", 1, 32'h100, 0, 0, 0, 0, 0);
        cyc("basic", 0, 0, 0, 1, 0, 0, 0);
        cyc("basic", 0, 0, 0, 0, 0, 0, 0);
        cyc("basic", 0, 0, 0, 0, 1, 32'hDEADBEEF, 0);
        chk("basic.valid_at4", {31'b0, instructionValid}, 32'd1);
        chk("basic.word", instruction, 32'hDEADBEEF);
        repeat (3) cyc("basic.hold", 0, 0, 0, 0, 0, 0, 0);
        cyc("basic.acc", 0, 0, 0, 0, 0, 0, 1);

        // stalled address phase with stray data
        cyc("stall", 1, 32'h180, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            cyc("stall", 0, 0, 0, 0, (i == 2), 32'h1111_2222, 0);
        cyc("stall", 0, 0, 0, 1, 0, 0, 0);
        cyc("stall", 0, 0, 0, 0, 1, 32'hCAFE0001, 0);
        cyc("stall", 0, 0, 0, 0, 0, 0, 1);

        // flush in WAIT_DATA, data 2 cycles later, then 0x200
        cyc("flushw", 1, 32'h1C0, 0, 0, 0, 0, 0);
        cyc("flushw", 0, 0, 0, 1, 0, 0, 0);
        cyc("flushw", 0, 0, 1, 0, 0, 0, 0);
        cyc("flushw", 0, 0, 0, 0, 0, 0, 0);
        cyc("flushw", 0, 0, 0, 0, 1, 32'hBAD0BAD0, 0);
        chk("flushw.idle", {31'b0, fetchBusy}, 32'd0);
        cyc("f200", 1, 32'h200, 0, 0, 0, 0, 0);
        cyc("f200", 0, 0, 0, 1, 0, 0, 0);
        cyc("f200", 0, 0, 0, 0, 1, 32'h0000_0200, 0);
        cyc("f200", 0, 0, 0, 0, 0, 0, 1);

        // misaligned start, then a clean one
        cyc("mis", 1, 32'h102, 0, 0, 0, 0, 0);
        chk("mis.code", {30'b0, faultCode}, 32'd1);
        cyc("mis", 0, 0, 0, 1, 1, 0, 0);
        cyc("mis.clr", 1, 32'h10, 0, 0, 0, 0, 0);
        chk("mis.cleared", {30'b0, faultCode}, 32'd0);
        cyc("mis.clr", 0, 0, 0, 1, 0, 0, 0);
        cyc("mis.clr", 0, 0, 0, 0, 1, 32'h77, 0);
        cyc("mis.clr", 0, 0, 0, 0, 0, 0, 1);

        // timeout
        cyc("tmo", 1, 32'h300, 0, 0, 0, 0, 0);
        cyc("tmo", 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < T + 3; i++) cyc("tmo", 0, 0, 0, 0, 0, 0, 0);
        chk("tmo.code", {30'b0, faultCode}, 32'd2);

        // accept + start in HOLD
        cyc("b2b", 1, 32'h400, 0, 0, 0, 0, 0);
        cyc("b2b", 0, 0, 0, 1, 0, 0, 0);
        cyc("b2b", 0, 0, 0, 0, 1, 32'h4444, 0);
        cyc("b2b", 1, 32'h104, 0, 0, 0, 0, 1);
        chk("b2b.busRead", {31'b0, busRead}, 32'd1);
        chk("b2b.addr", busAddress, 32'h104);

        // reset mid-WAIT_DATA
        cyc("rst", 0, 0, 0, 1, 0, 0, 0);
        #2 reset = 1'b0;
        #1 check_zero("rst.mid");
        model_reset();
        idle_in();
        @(posedge clk);
        #1 reset = 1'b1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pc;
            pc = {$urandom_range(0, 255), 2'b00};
            if ($urandom_range(0, 9) == 0) pc[1:0] = 2'($urandom_range(1, 3));
            cyc("rand", ($urandom_range(0, 3) == 0), pc, ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0), $urandom,
                ($urandom_range(0, 2) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly downstream of the program counter: it takes the `nextPC` value the PC register produces, issues a single-beat read on the instruction bus, and holds the returned word with its PC for the decode stage. It handles the address/data bus handshake, flush of in-flight fetches, misalignment detection and a bus-response timeout. There is one outstanding transaction at most; no prefetch.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles allowed in WAIT_DATA/DRAIN before a timeout fault; counter width `$clog2(TIMEOUT_CYCLES+1)`.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fetchStart`  in  1  one-cycle request to fetch at `nextPC`.
- `nextPC`  in  32  fetch address from program counter.
- `flush`  in  1  discard current fetch (redirect/exception).
- `busAddress`  out  32  instruction bus address.
- `busRead`  out  1  address-phase valid.
- `busReady`  in  1  bus accepts address when `busRead && busReady`.
- `busDataValid`  in  1  read data valid.
- `busData`  in  32  read data.
- `instruction`  out  32  fetched word.
- `instructionPC`  out  32  address of `instruction`.
- `instructionValid`  out  1  `instruction` valid for decode.
- `instructionAccept`  in  1  decode consumes word.
- `fetchBusy`  out  1  high in any state except IDLE.
- `fetchFault`  out  1  sticky fault flag.
- `faultCode`  out  2  01 misaligned, 10 timeout, 00 none.

## Operation
- States: IDLE, REQUEST, WAIT_DATA, HOLD, DRAIN.
- IDLE: on `fetchStart`, `faultCode`/`fetchFault` clear. If `nextPC[1:0]!=0`, set fault 01 and stay in IDLE. Otherwise latch `nextPC` into the address register and go to REQUEST.
- REQUEST: `busRead=1`, `busAddress`=latched address, held stable until accepted. On `busReady`, clear the timer and go to WAIT_DATA. `busDataValid` is ignored in REQUEST.
- WAIT_DATA: on `busDataValid`, capture `busData` into `instruction`, copy the address to `instructionPC`, and go to HOLD. Otherwise the timer increments. When the timer reaches `TIMEOUT_CYCLES`, set fault 10 and go to IDLE.
- HOLD: `instructionValid=1`, with `instruction`/`instructionPC` stable.
  - On `instructionAccept`, go to IDLE.
  - If `instructionAccept && fetchStart` in the same cycle, perform the IDLE start check directly (go to REQUEST, or set fault 01 and go to IDLE).
- DRAIN: wait for `busDataValid`, discard the data, go to IDLE. Timeout applies as in WAIT_DATA (fault 10, go to IDLE).
- `fetchStart` outside IDLE, or outside the HOLD+accept case, is ignored.
- `flush` has priority over `fetchStart`, `busReady`, `busDataValid` and `instructionAccept`:
  - IDLE: no effect, and a same-cycle `fetchStart` is dropped.
  - REQUEST: withdraw `busRead` and go to IDLE. If `busReady` arrives the same cycle, the address counts as accepted, so go to DRAIN.
  - WAIT_DATA: go to DRAIN. If `busDataValid` arrives the same cycle, the data is discarded and the state goes to IDLE.
  - HOLD: clear `instructionValid` and go to IDLE.
  - DRAIN: no additional effect.
- Fault flags stay set until the next accepted `fetchStart` (one that is not dropped or ignored).
- Reset (any state, mid-transaction included): state IDLE.
  - Outputs go to 0: `busRead`, `busAddress`, `instruction`, `instructionPC`, `instructionValid`, `fetchBusy`, `fetchFault`, `faultCode`.
  - Timer goes to 0.
  - The bus is reset concurrently, so no drain is needed.

## Timing
- All outputs are registered.
- `fetchStart` at cycle 0 gives `busRead=1` at cycle 1.
- `busReady` sampled high at cycle n gives `busRead=0` at n+1.
- `busDataValid` at cycle k gives `instructionValid=1` at k+1.
- Minimum start-to-valid latency: 3 cycles (ready at 1, data at 2, valid at 3).
- `instructionAccept` at cycle h gives `instructionValid=0` at h+1. Back-to-back start gives `busRead=1` at h+1.
- Timeout: fault 10 and IDLE at the cycle after the timer equals `TIMEOUT_CYCLES` without data.
- Misaligned start: `fetchFault=1`, `faultCode=01` at cycle 1, with `busRead` never asserted.

## Test plan
- Reset, then start `nextPC=0x100`; `busReady` at 1; `busData=0xDEADBEEF` at 3. Required: `busAddress=0x100` while `busRead=1`; `instructionValid`=1 at 4 with `instruction=0xDEADBEEF`, `instructionPC=0x100`; held until accept.
- `busReady` low for 5 cycles in REQUEST, with `busDataValid` pulsed during REQUEST. Required: `busRead`/`busAddress` stable the whole time; the stray data is ignored; the fetch completes normally afterward.
- Flush in WAIT_DATA, then data arrives 2 cycles later. Required: no `instructionValid`, return to IDLE the cycle after the data, next fetch at `0x200` works.
- `nextPC=0x102` start. Required: `faultCode=01`, no bus activity. The next valid start clears the fault.
- No `busDataValid` with `TIMEOUT_CYCLES=4`. Required: fault 10 and IDLE after 4 waiting cycles.
- Reset asserted mid-WAIT_DATA, or HOLD with accept+start (`0x104`) in the same cycle. Required: reset gives all outputs 0 immediately; accept+start gives `busRead=1` next cycle with no idle bubble.
